// File: rtl/uc_pkg.sv
// Shared opcode encodings and audio FSM states for the stacked control unit.
package uc_pkg;

    localparam logic [5:0] OP_JMP   = 6'b001001;
    localparam logic [5:0] OP_JZ    = 6'b001010;
    localparam logic [5:0] OP_JNZ   = 6'b001011;
    localparam logic [5:0] OP_IN    = 6'b001100;
    localparam logic [5:0] OP_OUTR  = 6'b001101;
    localparam logic [5:0] OP_OUTI  = 6'b001110;
    localparam logic [5:0] OP_REL   = 6'b011001;
    localparam logic [5:0] OP_CALL  = 6'b011010;
    localparam logic [5:0] OP_RET   = 6'b011011;
    localparam logic [5:0] OP_ALOAD = 6'b011100;
    localparam logic [5:0] OP_PLAY  = 6'b011101;
    localparam logic [5:0] OP_FREQ  = 6'b011110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } audio_state_e;

endpackage

// File: rtl/uc_stack_if.sv
// Bundle between the control unit and its surroundings: instruction fields in,
// datapath selects, port enables, audio controls and status flags out.
interface uc_stack_if #(
    parameter int NPORTS = 4,
    parameter int PC_W   = 10,
    parameter int PSEL_W = $clog2(NPORTS)
);

    logic [5:0]        opcode;
    logic              z;
    logic [PSEL_W-1:0] port_a;
    logic [PSEL_W-1:0] port_b;
    logic [PC_W-1:0]   pc_plus1;
    logic              audio_done;

    logic [2:0]        op;
    logic              we3;
    logic              s_inc;
    logic              s_inm;
    logic              sel_in;
    logic              sel_out;
    logic              s_rel;
    logic              s_ret;
    logic [NPORTS-1:0] port_en;
    logic              audio_load;
    logic              audio_act;
    logic              s_cont;
    logic [PC_W-1:0]   ret_addr;
    logic              stall;
    logic              stack_ovf;
    logic              stack_unf;
    logic              audio_to;

    modport slave (
        input  opcode, z, port_a, port_b, pc_plus1, audio_done,
        output op, we3, s_inc, s_inm, sel_in, sel_out, s_rel, s_ret,
               port_en, audio_load, audio_act, s_cont, ret_addr, stall,
               stack_ovf, stack_unf, audio_to
    );

    modport master (
        output opcode, z, port_a, port_b, pc_plus1, audio_done,
        input  op, we3, s_inc, s_inm, sel_in, sel_out, s_rel, s_ret,
               port_en, audio_load, audio_act, s_cont, ret_addr, stall,
               stack_ovf, stack_unf, audio_to
    );

endinterface

// File: rtl/uc_stack_ret_stack.sv
// Return-address LIFO. The pointer has one extra bit so "full" (sp==DEPTH) is
// representable and the pointer never wraps; over/underflow are refused here.
module ret_stack #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [PC_W-1:0]  mem_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [IDX_W-1:0] topIdx;
    logic             doPush;
    logic             doPop;

    assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty_o = (sp_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign topIdx  = IDX_W'(sp_q - 1'b1);
    assign top_o   = empty_o ? '0 : mem_q[topIdx];

    always_comb begin
        sp_d = sp_q;
        if (doPush) begin
            sp_d = sp_q + 1'b1;
        end else if (doPop) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: an entry is only ever read below the pointer.
    always_ff @(posedge clk) begin
        if (!reset && doPush) begin
            mem_q[sp_q[IDX_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uc_stack.sv
// Single-cycle control unit with one-hot port enables, a nesting return-address
// stack and an audio-play FSM that freezes the PC until done or timeout.
module uc_stack
    import uc_pkg::*;
#(
    parameter int NPORTS        = 4,
    parameter int PSEL_W        = $clog2(NPORTS),
    parameter int PC_W          = 10,
    parameter int STACK_DEPTH   = 8,
    parameter int AUDIO_TIMEOUT = 1024
) (
    input logic         clk,
    input logic         reset,
    uc_stack_if.slave   bus
);

    localparam int CNT_W = $clog2(AUDIO_TIMEOUT);

    audio_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              to_q, to_d;

    logic              push;
    logic              pop;
    logic              stackFull;
    logic              stackEmpty;
    logic [PC_W-1:0]   stackTop;
    logic [PSEL_W-1:0] portSel;
    logic              portWr;

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (bus.pc_plus1),
        .top_o   (stackTop),
        .full_o  (stackFull),
        .empty_o (stackEmpty)
    );

    assign bus.op        = bus.opcode[2:0];
    assign bus.ret_addr  = stackTop;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
    assign bus.audio_to  = to_q;
    assign bus.port_en   = portWr ? (NPORTS'(1) << portSel) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        bus.we3        = 1'b0;
        bus.s_inc      = 1'b1;
        bus.s_inm      = 1'b0;
        bus.sel_in     = 1'b0;
        bus.sel_out    = 1'b0;
        bus.s_rel      = 1'b0;
        bus.s_ret      = 1'b0;
        bus.audio_load = 1'b0;
        bus.audio_act  = 1'b0;
        bus.s_cont     = 1'b0;
        bus.stall      = 1'b0;
        portWr         = 1'b0;
        portSel        = bus.port_a;
        push           = 1'b0;
        pop            = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        unf_d          = unf_q;
        to_d           = to_q;

        if (!reset) begin
            case (state_q)
                // The opcode is frozen while playing, so decode is ignored here.
                ST_PLAY: begin
                    bus.audio_act = 1'b1;
                    if (bus.audio_done) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_W'(AUDIO_TIMEOUT - 1)) begin
                        to_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bus.s_inc = 1'b0;
                        bus.stall = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                    end
                end
                default: begin
                    casez (bus.opcode)
                        6'b??0???: bus.we3 = 1'b1;
                        6'b??1000: begin
                            bus.we3   = 1'b1;
                            bus.s_inm = 1'b1;
                        end
                        OP_JMP:  bus.s_inc = 1'b0;
                        OP_JZ:   bus.s_inc = !bus.z;
                        OP_JNZ:  bus.s_inc = bus.z;
                        OP_IN: begin
                            bus.we3    = 1'b1;
                            bus.sel_in = 1'b1;
                        end
                        OP_OUTR: begin
                            bus.sel_out = 1'b1;
                            portWr      = 1'b1;
                        end
                        OP_OUTI: portWr = 1'b1;
                        6'b??1111: begin
                            bus.sel_out = 1'b1;
                            portWr      = 1'b1;
                            portSel     = bus.port_b;
                        end
                        OP_REL:   bus.s_rel = 1'b1;
                        OP_CALL: begin
                            bus.s_inc = 1'b0;
                            if (stackFull) begin
                                ovf_d = 1'b1;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (stackEmpty) begin
                                unf_d = 1'b1;
                            end else begin
                                bus.s_ret = 1'b1;
                                bus.s_inc = 1'b0;
                                pop       = 1'b1;
                            end
                        end
                        OP_ALOAD: bus.audio_load = 1'b1;
                        OP_PLAY: begin
                            bus.audio_act = 1'b1;
                            if (!bus.audio_done) begin
                                bus.s_inc = 1'b0;
                                bus.stall = 1'b1;
                                state_d   = ST_PLAY;
                                cnt_d     = CNT_W'(1);
                            end
                        end
                        OP_FREQ: begin
                            bus.audio_act = 1'b1;
                            bus.s_cont    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule
